// File: rtl/adc_conv_pkg.sv
// Shared helpers for the ADC I/Q converter: offset-binary to signed conversion and saturation.
package adc_conv_pkg;

  localparam int unsigned MaxW      = 32;
  localparam int unsigned AdcWDflt  = 8;
  localparam int unsigned PairWDflt = 2 * (AdcWDflt + 1);

  // 2x - (2^w - 1); exact for w < MaxW.
  function automatic logic signed [MaxW:0] offset_to_signed(input logic [MaxW-1:0] x,
                                                             input int unsigned w);
    logic [MaxW:0] ones;
    ones = '0;
    for (int unsigned i = 0; i < MaxW; i++) begin
      if (i < w) ones[i] = 1'b1;
    end
    return $signed({x, 1'b0}) - $signed(ones);
  endfunction

  function automatic logic signed [MaxW:0] sat_signed(input logic signed [MaxW:0] v,
                                                      input int unsigned width);
    logic signed [MaxW:0] hi;
    logic signed [MaxW:0] lo;
    hi = '0;
    for (int unsigned i = 0; i < MaxW; i++) begin
      if (i + 1 < width) hi[i] = 1'b1;
    end
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous show-ahead FIFO; output holds the last popped word while empty.
module adc_sample_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             rd_ok, wr_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AddrW + 1)'(DEPTH));
  assign count_o = count_q;

  // A full FIFO still accepts a write when the same cycle pops.
  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full_o | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
      hold_d   = mem_q[rd_ptr_q];
    end
    if (wr_ok && !rd_ok) count_d = count_q + (AddrW + 1)'(1);
    if (!wr_ok && rd_ok) count_d = count_q - (AddrW + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? hold_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/adc_iq_signed_conv.sv
// ADC I/Q capture, offset-binary to signed conversion and stream FIFO.
// Optional DC removal stage enabled by defining ADC_DC_REMOVE_EN.
module adc_iq_signed_conv
  import adc_conv_pkg::*;
#(
  parameter int unsigned ADC_W       = AdcWDflt,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DC_SHIFT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] adc_i,
  input  logic [ADC_W-1:0] adc_q,
  input  logic             adc_eoc,
  output logic [ADC_W:0]   out_i,
  output logic [ADC_W:0]   out_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned OutW  = ADC_W + 1;
  localparam int unsigned PairW = 2 * OutW;

  // Sync/history reset high so an eoc held across reset is not a rising edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   eoc_prev_q;
  logic                   eoc_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      eoc_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], adc_eoc};
      eoc_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign eoc_rise = sync_q[SYNC_STAGES-1] & ~eoc_prev_q;

  logic             cap_vld_q;
  logic [ADC_W-1:0] cap_i_q, cap_q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld_q <= 1'b0;
      cap_i_q   <= '0;
      cap_q_q   <= '0;
    end else begin
      cap_vld_q <= eoc_rise;
      if (eoc_rise) begin
        cap_i_q <= adc_i;
        cap_q_q <= adc_q;
      end
    end
  end

  logic signed [OutW-1:0] y_i, y_q;
  assign y_i = OutW'(offset_to_signed(MaxW'(cap_i_q), ADC_W));
  assign y_q = OutW'(offset_to_signed(MaxW'(cap_q_q), ADC_W));

  logic             wr_en;
  logic [PairW-1:0] wr_data;

`ifdef ADC_DC_REMOVE_EN
  localparam int unsigned AccW = OutW + DC_SHIFT;

  logic signed [AccW-1:0] acc_i_q, acc_q_q;
  logic signed [OutW:0]   diff_i, diff_q;
  logic signed [OutW-1:0] res_i, res_q;
  logic signed [OutW-1:0] dc_i_q, dc_q_q;
  logic                   dc_vld_q;

  // The shifted estimate always fits OutW bits, so truncation keeps its value.
  assign diff_i = (OutW + 1)'(y_i) - (OutW + 1)'(acc_i_q >>> DC_SHIFT);
  assign diff_q = (OutW + 1)'(y_q) - (OutW + 1)'(acc_q_q >>> DC_SHIFT);
  assign res_i  = OutW'(sat_signed((MaxW + 1)'(diff_i), OutW));
  assign res_q  = OutW'(sat_signed((MaxW + 1)'(diff_q), OutW));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      dc_i_q   <= '0;
      dc_q_q   <= '0;
      dc_vld_q <= 1'b0;
    end else begin
      dc_vld_q <= cap_vld_q;
      if (cap_vld_q) begin
        acc_i_q <= acc_i_q + AccW'(diff_i);
        acc_q_q <= acc_q_q + AccW'(diff_q);
        dc_i_q  <= res_i;
        dc_q_q  <= res_q;
      end
    end
  end

  assign wr_en   = dc_vld_q;
  assign wr_data = {dc_i_q, dc_q_q};
`else
  assign wr_en   = cap_vld_q;
  assign wr_data = {y_i, y_q};
`endif

  logic [PairW-1:0] rd_data;
  logic             fifo_full, fifo_empty;
  logic             pop, drop;

  adc_sample_fifo #(
    .WIDTH (PairW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (out_ready),
    .rd_data_o (rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   ()
  );

  assign pop  = out_ready & ~fifo_empty;
  assign drop = wr_en & fifo_full & ~pop;

  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = ~fifo_empty;
  assign out_i     = rd_data[PairW-1:OutW];
  assign out_q     = rd_data[OutW-1:0];
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_adc_iq_signed_conv.sv
// Directed bench for adc_iq_signed_conv (default build; DC-removal test when ADC_DC_REMOVE_EN).
module tb_adc_iq_signed_conv;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] adc_i, adc_q;
  logic       adc_eoc;
  logic [8:0] out_i, out_q;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic [7:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adc_iq_signed_conv #(
    .ADC_W       (8),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2),
    .CNT_W       (8),
    .DC_SHIFT    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .adc_i     (adc_i),
    .adc_q     (adc_q),
    .adc_eoc   (adc_eoc),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // eoc high 3 clk, low 3 clk; data held until the next pulse.
  task automatic pulse(input logic [7:0] vi, input logic [7:0] vq);
    adc_i   = vi;
    adc_q   = vq;
    adc_eoc = 1'b1;
    tick(3);
    adc_eoc = 1'b0;
    tick(3);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  function automatic int si(input logic [8:0] v);
    return int'($signed(v));
  endfunction

  logic [7:0] vin [4];
  int         exp_i [4];
  int         exp_q [4];

  initial begin
    rst       = 1'b1;
    adc_i     = 8'h00;
    adc_q     = 8'h00;
    adc_eoc   = 1'b0;
    out_ready = 1'b0;
    tick(3);
    check("rst_valid", int'(out_valid), 0);
    check("rst_out_i", si(out_i), 0);
    check("rst_out_q", si(out_q), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    rst = 1'b0;
    tick(2);

`ifdef ADC_DC_REMOVE_EN
    // Constant I=0xC0 (+129), Q=0x40 (-127): DC estimate converges to the input.
    for (int n = 1; n <= 400; n++) begin
      pulse(8'hC0, 8'h40);
      if (n == 1) begin
        check("dc_valid1", int'(out_valid), 1);
        check("dc_i1", si(out_i), 129);
        check("dc_q1", si(out_q), -127);
      end
      if (n == 2) begin
        check("dc_i2", si(out_i), 121);
        check("dc_q2", si(out_q), -119);
      end
      if (n == 400) begin
        check("dc_i400", si(out_i), 0);
        check("dc_q400", si(out_q), 0);
      end
      pop_one();
    end
    check("dc_empty", int'(out_valid), 0);
`else
    // Test 1: conversion corners and latency.
    vin   = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    exp_i = '{-255, -1, 1, 255};
    exp_q = '{255, 1, -1, -255};
    for (int k = 0; k < 4; k++) begin
      adc_i   = vin[k];
      adc_q   = ~vin[k];
      adc_eoc = 1'b1;
      tick(3);
      check("conv_early", int'(out_valid), 0);
      adc_eoc = 1'b0;
      tick(1);
      check("conv_valid", int'(out_valid), 1);
      check("conv_i", si(out_i), exp_i[k]);
      check("conv_q", si(out_q), exp_q[k]);
      pop_one();
      check("conv_popped", int'(out_valid), 0);
      tick(2);
    end
    check("hold_last_i", si(out_i), 255);

    // Test 2: five samples into a depth-4 FIFO with no pops.
    for (int n = 1; n <= 5; n++) pulse(8'(n), 8'(8'h80 + n));
    tick(2);
    check("ovf_drop_cnt", int'(drop_cnt), 1);
    check("ovf_flag", int'(overflow), 1);
    for (int n = 1; n <= 4; n++) begin
      check("ovf_valid", int'(out_valid), 1);
      check("ovf_order_i", si(out_i), 2 * n - 255);
      check("ovf_order_q", si(out_q), 2 * n + 1);
      pop_one();
    end
    check("ovf_drained", int'(out_valid), 0);

    // Test 3: full FIFO, write coincides with a pop.
    for (int n = 0; n < 4; n++) pulse(8'(8'h10 + n), 8'h80);
    check("full_head", si(out_i), -223);
    adc_i   = 8'h20;
    adc_eoc = 1'b1;
    tick(3);
    out_ready = 1'b1;
    adc_eoc   = 1'b0;
    tick(1);
    out_ready = 1'b0;
    check("simul_drop_cnt", int'(drop_cnt), 1);
    exp_i = '{-221, -219, -217, -191};
    for (int k = 0; k < 4; k++) begin
      check("simul_valid", int'(out_valid), 1);
      check("simul_i", si(out_i), exp_i[k]);
      pop_one();
    end
    check("simul_count4", int'(out_valid), 0);
    tick(2);

    // Test 4: eoc held high across reset release.
    adc_eoc = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(6);
    check("eochigh_valid", int'(out_valid), 0);
    check("eochigh_drop_cnt", int'(drop_cnt), 0);
    check("eochigh_overflow", int'(overflow), 0);
    adc_eoc = 1'b0;
    tick(3);
    pulse(8'h40, 8'hC0);
    tick(2);
    check("eochigh_one_valid", int'(out_valid), 1);
    check("eochigh_one_i", si(out_i), -127);
    check("eochigh_one_q", si(out_q), 129);
    pop_one();
    tick(4);
    check("eochigh_only_one", int'(out_valid), 0);

    // Test 5: reset with three queued and one in flight.
    for (int n = 0; n < 3; n++) pulse(8'(8'h50 + n), 8'h80);
    check("midrst_queued", int'(out_valid), 1);
    adc_i   = 8'h53;
    adc_eoc = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_out_i", si(out_i), 0);
    adc_eoc = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(10);
    check("midrst_after", int'(out_valid), 0);
    check("midrst_drop_cnt", int'(drop_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
